// File: rtl/alu_seq.sv
// Registered, valid/ready-handshaked ALU: ARITH, rotate left/right and an
// iterative shift-add unsigned multiply, with a flags register whose carry can chain.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             nb,
   input  logic             ic,
   input  logic             na,
   input  logic             xo,
   input  logic             no,
   input  logic             use_cf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] hi,
   output logic             cf,
   output logic             zf,
   output logic             sf
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {OP_ARITH = 2'b00, OP_ROTL = 2'b01, OP_MUL = 2'b10, OP_ROTR = 2'b11} op_t;
   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state, state_nx;
   logic [SHW-1:0]         cnt;
   logic [2*WIDTH-1:0]     mcand, acc, acc_step;
   logic [WIDTH-1:0]       mplier;
   logic                   accept, last_step;

   logic [WIDTH-1:0]       x, y, z, arith_o;
   logic                   carry, cm, arith_cf;
   logic [SHW-1:0]         amt;
   logic [2*WIDTH-1:0]     rotl_w, rotr_w;
   logic [WIDTH-1:0]       res_o;
   logic                   res_cf;

   assign accept    = in_valid & in_ready;
   assign last_step = (state == BUSY) && (cnt == SHW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept && op_t'(op) == OP_MUL) state_nx = BUSY;
         BUSY: if (last_step) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE) && (!out_valid || out_ready);
   end

   // Ripple chain; ic masks the carry seen by each stage, not only the carry-in.
   always_comb begin
      x     = a ^ {WIDTH{na}};
      y     = b ^ {WIDTH{nb}};
      z     = '0;
      carry = use_cf ? cf : ci;
      cm    = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cm    = carry & ~ic;
         z[i]  = (x[i] ^ y[i] ^ cm) | (x[i] & y[i] & xo);
         carry = (x[i] & y[i]) | (cm & (x[i] ^ y[i]));
      end
      arith_o  = z ^ {WIDTH{no}};
      arith_cf = carry;
   end

   always_comb begin
      amt    = b[SHW-1:0];
      rotl_w = {a, a} << amt;
      rotr_w = {a, a} >> amt;
      res_o  = arith_o;
      res_cf = arith_cf;
      case (op_t'(op))
         OP_ROTL: begin
            res_o  = rotl_w[2*WIDTH-1:WIDTH];
            res_cf = (amt != '0) & rotl_w[WIDTH];
         end
         OP_ROTR: begin
            res_o  = rotr_w[WIDTH-1:0];
            res_cf = (amt != '0) & rotr_w[WIDTH-1];
         end
         default: ;
      endcase
   end

   assign acc_step = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         o         <= '0;
         hi        <= '0;
         cf        <= 1'b0;
         zf        <= 1'b0;
         sf        <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
      end else if (accept) begin
         if (op_t'(op) == OP_MUL) begin
            mcand     <= {{WIDTH{1'b0}}, a};
            mplier    <= b;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
         end else begin
            o         <= res_o;
            hi        <= '0;
            cf        <= res_cf;
            zf        <= (res_o == '0);
            sf        <= res_o[WIDTH-1];
            out_valid <= 1'b1;
         end
      end else if (state == BUSY) begin
         acc    <= acc_step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (last_step) begin
            {hi, o}   <= acc_step;
            cf        <= (acc_step[2*WIDTH-1:WIDTH] != '0);
            zf        <= (acc_step[WIDTH-1:0] == '0);
            sf        <= acc_step[WIDTH-1];
            out_valid <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes hand-computed results at accept,
// a negedge monitor pops and compares whenever a result is consumed.
module tb_alu_seq;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] o;
      logic [W-1:0] hi;
      logic         cf;
      logic         zf;
      logic         sf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   op = '0;
   logic [W-1:0] a = '0, b = '0;
   logic         ci = 0, nb = 0, ic = 0, na = 0, xo = 0, no = 0, use_cf = 0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] o, hi;
   logic         cf, zf, sf;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   exp_t        sb[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .ci(ci), .nb(nb), .ic(ic), .na(na), .xo(xo), .no(no),
      .use_cf(use_cf), .out_valid(out_valid), .out_ready(out_ready),
      .o(o), .hi(hi), .cf(cf), .zf(zf), .sf(sf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got o=%h hi=%h, want no result", o, hi);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({o, hi, cf, zf, sf} !== e) begin
               n_err++;
               $display("FAIL result: got o=%h hi=%h cf=%b zf=%b sf=%b, want o=%h hi=%h cf=%b zf=%b sf=%b",
                        o, hi, cf, zf, sf, e.o, e.hi, e.cf, e.zf, e.sf);
            end
         end
      end
   end

   // ctl = {ci, nb, ic, na, xo, no}; call with time just after a rising edge
   task automatic issue(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [5:0] ctl_i, input logic ucf_i, input exp_t e);
      int unsigned t = 0;
      in_valid = 1'b1;
      op = op_i; a = a_i; b = b_i; use_cf = ucf_i;
      {ci, nb, ic, na, xo, no} = ctl_i;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end else begin
         sb.push_back(e);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      logic [W-1:0] hold_o;
      int unsigned  t;
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_o_hi", {16'd0, o, hi}, 32'd0);
      chk("rst_flags", {29'd0, cf, zf, sf}, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      issue(2'b00, 8'hF0, 8'h20, 6'b000000, 1'b0, '{8'h10, 8'h00, 1, 0, 0});
      chk("arith_latency", 32'(out_valid), 32'd1);

      // multi-word: carry chains into the immediately following op
      issue(2'b00, 8'hFF, 8'h01, 6'b000000, 1'b0, '{8'h00, 8'h00, 1, 1, 0});
      issue(2'b00, 8'h00, 8'h00, 6'b000000, 1'b1, '{8'h01, 8'h00, 0, 0, 0});
      issue(2'b00, 8'hFF, 8'h01, 6'b000000, 1'b0, '{8'h00, 8'h00, 1, 1, 0});
      idle(3);
      issue(2'b00, 8'h00, 8'h00, 6'b000000, 1'b1, '{8'h01, 8'h00, 0, 0, 0});

      // logic ops: ic=1 xo=1 gives OR, plus no=1 gives NOR
      issue(2'b00, 8'hC3, 8'h0F, 6'b001010, 1'b0, '{8'hCF, 8'h00, 0, 0, 1});
      issue(2'b00, 8'hC3, 8'h0F, 6'b001011, 1'b0, '{8'h30, 8'h00, 0, 0, 0});

      // subtract under backpressure
      idle(1);
      out_ready = 1'b0;
      issue(2'b00, 8'h05, 8'h07, 6'b110000, 1'b0, '{8'hFE, 8'h00, 0, 0, 1});
      hold_o = o;
      in_valid = 1'b1; op = 2'b01; a = 8'h55; b = 8'h01;
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_o", 32'(o), 32'(hold_o));
         chk("stall_flags", {29'd0, cf, zf, sf}, 32'b001);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(1);
      issue(2'b00, 8'h07, 8'h05, 6'b110000, 1'b0, '{8'h02, 8'h00, 1, 0, 0});

      issue(2'b01, 8'h81, 8'h03, 6'b111111, 1'b1, '{8'h0C, 8'h00, 0, 0, 0});
      issue(2'b11, 8'h81, 8'h01, 6'b000000, 1'b0, '{8'hC0, 8'h00, 1, 0, 1});
      issue(2'b01, 8'h81, 8'h08, 6'b000000, 1'b0, '{8'h81, 8'h00, 0, 0, 1});

      // MUL latency and in_ready gating
      issue(2'b10, 8'hFF, 8'hFF, 6'b000000, 1'b0, '{8'h01, 8'hFE, 1, 0, 0});
      chk("mul_in_ready_0", 32'(in_ready), 32'd0);
      for (int i = 1; i < W; i++) begin
         @(posedge clk); #1;
         chk("mul_busy_valid", 32'(out_valid), 32'd0);
         chk("mul_busy_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      chk("mul_done_valid", 32'(out_valid), 32'd1);
      issue(2'b10, 8'h00, 8'h7F, 6'b000000, 1'b1, '{8'h00, 8'h00, 0, 1, 0});
      idle(W + 1);

      // reset during BUSY step 3 discards the multiply
      issue(2'b10, 8'hFF, 8'hFF, 6'b000000, 1'b0, '{8'h01, 8'hFE, 1, 0, 0});
      idle(3);
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_o_hi", {16'd0, o, hi}, 32'd0);
      chk("midrst_flags", {29'd0, cf, zf, sf}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
      repeat (W + 2) begin
         @(posedge clk); #1;
         chk("postrst_no_result", 32'(out_valid), 32'd0);
      end
      issue(2'b00, 8'h01, 8'h01, 6'b000000, 1'b1, '{8'h02, 8'h00, 0, 0, 0});

      t = 0;
      while (sb.size() != 0 && t < 50) begin
         t++;
         @(posedge clk); #1;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
